// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle EX-stage ALU.
// Holds the 4-bit operation codes, the R-type function codes, the ALUop
// encodings and the state type of the iterative MUL/DIV engine.
package alu_pkg;

  // Decoded operation codes driven on the 'operation' port
  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;
  localparam logic [3:0] OP_REMU = 4'b1010;

  // R-type function codes (ALUop = 2'b10)
  localparam logic [3:0] FN_ADD  = 4'b0000;
  localparam logic [3:0] FN_SUB  = 4'b0010;
  localparam logic [3:0] FN_AND  = 4'b0100;
  localparam logic [3:0] FN_OR   = 4'b0101;
  localparam logic [3:0] FN_NOR  = 4'b0111;
  localparam logic [3:0] FN_SLT  = 4'b1010;
  localparam logic [3:0] FN_MUL  = 4'b1000;
  localparam logic [3:0] FN_DIVU = 4'b1001;
  localparam logic [3:0] FN_REMU = 4'b1011;

  // ALUop encodings from the main decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ILL   = 2'b11;

  // Iterative engine states
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } state_t;

endpackage

// File: rtl/alu_control_dec.sv
// ALU control decoder: purely combinational.
// Ports:
//   ALUop        in  2        operation class from the main decoder
//   functionCode in  FUNCT_W  R-type function select
//   operation    out 4        decoded operation code
//   illegal      out 1        ALUop/funct combination is not defined
//   multicycle   out 1        operation needs the iterative engine (MUL/DIVU/REMU)
// Illegal encodings decode to ADD so the datapath sees a harmless op.
module alu_control_dec
  import alu_pkg::*;
#(
  parameter int FUNCT_W = 4
) (
  input  logic [1:0]         ALUop,
  input  logic [FUNCT_W-1:0] functionCode,
  output logic [3:0]         operation,
  output logic               illegal,
  output logic               multicycle
);

  always_comb begin
    operation  = OP_ADD;
    illegal    = 1'b0;
    multicycle = 1'b0;
    case (ALUop)
      ALUOP_ADD: operation = OP_ADD;
      ALUOP_SUB: operation = OP_SUB;
      ALUOP_ILL: illegal   = 1'b1;
      ALUOP_RTYPE: begin
        case (functionCode)
          FUNCT_W'(FN_ADD):  operation = OP_ADD;
          FUNCT_W'(FN_SUB):  operation = OP_SUB;
          FUNCT_W'(FN_AND):  operation = OP_AND;
          FUNCT_W'(FN_OR):   operation = OP_OR;
          FUNCT_W'(FN_NOR):  operation = OP_NOR;
          FUNCT_W'(FN_SLT):  operation = OP_SLT;
          FUNCT_W'(FN_MUL):  begin operation = OP_MUL;  multicycle = 1'b1; end
          FUNCT_W'(FN_DIVU): begin operation = OP_DIVU; multicycle = 1'b1; end
          FUNCT_W'(FN_REMU): begin operation = OP_REMU; multicycle = 1'b1; end
          default:           illegal = 1'b1;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_multicycle_ex.sv
// EX-stage ALU with integrated ALU control and iterative MUL/DIVU/REMU.
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   flush                abort any in-flight op; an accept in the same cycle is dropped
//   in_valid / in_ready  issue handshake; in_ready is high in IDLE and DONE
//   ALUop, functionCode  operation select, decoded by alu_control_dec
//   a, b                 WIDTH-bit operands (unsigned for MUL/DIV)
//   operation            registered decoded op of the last accepted instruction
//   out_valid            one-cycle result pulse
//   result               result (MUL returns the low WIDTH bits)
//   zero, illegal,
//   div_by_zero          status flags, only meaningful while out_valid is high
// Single-cycle ops return one cycle after acceptance. MUL is shift-add and
// DIVU/REMU is restoring division, both one bit per cycle, finishing in DONE
// WIDTH+1 cycles after acceptance.
module alu_multicycle_ex
  import alu_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int FUNCT_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         ALUop,
  input  logic [FUNCT_W-1:0] functionCode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [3:0]         operation,
  output logic               out_valid,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               illegal,
  output logic               div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic [WIDTH-1:0]   mcand, mplier, acc;
  logic [WIDTH-1:0]   divisor, quot, rem;
  logic               is_rem;

  logic [3:0]         dec_op;
  logic               dec_illegal, dec_multi;
  logic               accept, b_zero, div_zero_case, start_iter;
  logic [WIDTH-1:0]   single_res, acc_next, rem_next, quot_next, iter_res;
  logic [WIDTH:0]     div_shift, div_diff;
  logic               div_bit;

  alu_control_dec #(.FUNCT_W(FUNCT_W)) u_dec (
    .ALUop        (ALUop),
    .functionCode (functionCode),
    .operation    (dec_op),
    .illegal      (dec_illegal),
    .multicycle   (dec_multi)
  );

  assign in_ready      = (state == ST_IDLE) || (state == ST_DONE);
  assign accept        = in_valid && in_ready;
  assign b_zero        = (b == '0);
  // Division by zero is answered immediately instead of iterating
  assign div_zero_case = ((dec_op == OP_DIVU) || (dec_op == OP_REMU)) && b_zero;
  assign start_iter    = dec_multi && !div_zero_case;

  // Single-cycle results, including the divide-by-zero answers
  always_comb begin
    single_res = '0;
    if (!dec_illegal) begin
      case (dec_op)
        OP_AND:  single_res = a & b;
        OP_OR:   single_res = a | b;
        OP_ADD:  single_res = a + b;
        OP_SUB:  single_res = a - b;
        OP_SLT:  single_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
        OP_NOR:  single_res = ~(a | b);
        OP_DIVU: single_res = '1;
        OP_REMU: single_res = a;
        default: single_res = '0;
      endcase
    end
  end

  // One iteration step of each engine. The partial remainder is always below
  // the divisor, so the shifted value fits in WIDTH+1 bits and the top bit of
  // the difference is a reliable borrow.
  always_comb begin
    acc_next  = acc + (mplier[0] ? mcand : '0);
    div_shift = {rem, quot[WIDTH-1]};
    div_diff  = div_shift - {1'b0, divisor};
    div_bit   = ~div_diff[WIDTH];
    rem_next  = div_bit ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    quot_next = {quot[WIDTH-2:0], div_bit};
    iter_res  = (state == ST_MUL) ? acc_next : (is_rem ? rem_next : quot_next);
  end

  // FSM, iterative engine and registered outputs. A new accept in DONE
  // overrides the default return to IDLE, giving bubble-free issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      count       <= '0;
      mcand       <= '0;
      mplier      <= '0;
      acc         <= '0;
      divisor     <= '0;
      quot        <= '0;
      rem         <= '0;
      is_rem      <= 1'b0;
      operation   <= '0;
      out_valid   <= 1'b0;
      result      <= '0;
      zero        <= 1'b0;
      illegal     <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      out_valid   <= 1'b0;
      zero        <= 1'b0;
      illegal     <= 1'b0;
      div_by_zero <= 1'b0;
      if (flush) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_MUL, ST_DIV: begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            rem    <= rem_next;
            quot   <= quot_next;
            count  <= count - 1'b1;
            if (count == '0) begin
              state     <= ST_DONE;
              out_valid <= 1'b1;
              result    <= iter_res;
              zero      <= (iter_res == '0);
            end
          end
          default: state <= ST_IDLE;
        endcase

        if (accept) begin
          operation <= dec_op;
          if (start_iter) begin
            state   <= (dec_op == OP_MUL) ? ST_MUL : ST_DIV;
            count   <= CNT_W'(WIDTH - 1);
            mcand   <= a;
            mplier  <= b;
            acc     <= '0;
            divisor <= b;
            quot    <= a;
            rem     <= '0;
            is_rem  <= (dec_op == OP_REMU);
          end else begin
            out_valid   <= 1'b1;
            result      <= single_res;
            zero        <= (single_res == '0);
            illegal     <= dec_illegal;
            div_by_zero <= div_zero_case;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_multicycle_ex.sv
// Self-checking bench for alu_multicycle_ex (WIDTH=16).
// A reference model computes each accepted instruction's result with plain
// arithmetic and records the clock edge at which it must appear; a monitor
// compares every cycle's outputs against that schedule.
module tb_alu_multicycle_ex;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, in_ready;
  logic [1:0]    ALUop;
  logic [3:0]    functionCode;
  logic [W-1:0]  a, b;
  logic [3:0]    operation;
  logic          out_valid, zero, illegal, div_by_zero;
  logic [W-1:0]  result;

  int checks = 0;
  int errors = 0;

  alu_multicycle_ex #(.WIDTH(W), .FUNCT_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .ALUop        (ALUop),
    .functionCode (functionCode),
    .a            (a),
    .b            (b),
    .operation    (operation),
    .out_valid    (out_valid),
    .result       (result),
    .zero         (zero),
    .illegal      (illegal),
    .div_by_zero  (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    int         lat;
    logic [3:0] op;
    logic [W-1:0] res;
    logic       ill;
    logic       dbz;
  } exp_t;

  exp_t q[$];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural reference: decode and evaluate with ordinary arithmetic
  function automatic exp_t model(input logic [1:0] aop, input logic [3:0] f,
                                 input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    e.due = 0; e.lat = 1; e.op = 4'b0010; e.res = '0; e.ill = 1'b0; e.dbz = 1'b0;
    if (aop == 2'b00) e.res = x + y;
    else if (aop == 2'b01) begin e.op = 4'b0110; e.res = x - y; end
    else if (aop == 2'b11) e.ill = 1'b1;
    else begin
      case (f)
        4'b0000: e.res = x + y;
        4'b0010: begin e.op = 4'b0110; e.res = x - y; end
        4'b0100: begin e.op = 4'b0000; e.res = x & y; end
        4'b0101: begin e.op = 4'b0001; e.res = x | y; end
        4'b0111: begin e.op = 4'b1100; e.res = ~(x | y); end
        4'b1010: begin e.op = 4'b0111; e.res = ($signed(x) < $signed(y)) ? 16'd1 : 16'd0; end
        4'b1000: begin e.op = 4'b1000; e.res = W'(32'(x) * 32'(y)); e.lat = W + 1; end
        4'b1001: begin
          e.op = 4'b1001;
          if (y == 0) begin e.dbz = 1'b1; e.res = '1; end
          else begin e.res = x / y; e.lat = W + 1; end
        end
        4'b1011: begin
          e.op = 4'b1010;
          if (y == 0) begin e.dbz = 1'b1; e.res = x; end
          else begin e.res = x % y; e.lat = W + 1; end
        end
        default: e.ill = 1'b1;
      endcase
    end
    return e;
  endfunction

  // Monitor: update the model at each edge, then check outputs 1 time unit later
  int n = 0;
  int ready_at = 0;
  always @(posedge clk) begin
    bit   rst_now;
    exp_t e;
    bit   exp_v;
    n++;
    rst_now = reset;
    if (reset) begin
      q.delete();
      ready_at = n + 1;
    end else if (flush) begin
      while (q.size() > 0 && q[$].due >= n) void'(q.pop_back());
      ready_at = n + 1;
    end else if (in_valid && n >= ready_at) begin
      e = model(ALUop, functionCode, a, b);
      e.due = n + e.lat - 1;
      ready_at = n + e.lat;
      q.push_back(e);
    end
    #1;
    if (rst_now) begin
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_result", 32'(result), 32'd0);
      checkOutput("rst_operation", 32'(operation), 32'd0);
      checkOutput("rst_flags", {29'd0, zero, illegal, div_by_zero}, 32'd0);
      checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    end else begin
      exp_v = (q.size() > 0) && (q[0].due == n);
      checkOutput("out_valid", 32'(out_valid), 32'(exp_v));
      checkOutput("in_ready", 32'(in_ready), 32'(n + 1 >= ready_at));
      if (exp_v && out_valid) begin
        e = q.pop_front();
        checkOutput("result", 32'(result), 32'(e.res));
        checkOutput("operation", 32'(operation), 32'(e.op));
        checkOutput("zero", 32'(zero), 32'(e.res == 0));
        checkOutput("illegal", 32'(illegal), 32'(e.ill));
        checkOutput("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
      end else if (exp_v) begin
        void'(q.pop_front());
      end
    end
  end

  task automatic applyStimulus(input logic v, input logic [1:0] aop, input logic [3:0] f,
                               input logic [W-1:0] x, input logic [W-1:0] y,
                               input logic fl, input logic rs);
    @(posedge clk);
    #2;
    in_valid = v; ALUop = aop; functionCode = f; a = x; b = y; flush = fl; reset = rs;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) applyStimulus(1'b0, 2'b00, 4'h0, '0, '0, 1'b0, 1'b0);
  endtask

  logic [3:0] legal_f [9] = '{4'h0, 4'h2, 4'h4, 4'h5, 4'h7, 4'hA, 4'h8, 4'h9, 4'hB};

  initial begin
    logic [1:0] aop;
    logic [3:0] f;
    logic [W-1:0] x, y;
    int r;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; ALUop = '0; functionCode = '0; a = '0; b = '0;
    applyStimulus(1'b0, 2'b00, 4'h0, '0, '0, 1'b0, 1'b1);
    idle(2);

    // Single-cycle directed cases
    applyStimulus(1'b1, 2'b10, 4'b0010, 16'd5, 16'd9, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b01, 4'h0, 16'h1234, 16'h1234, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b11, 4'h0, 16'd7, 16'd8, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b10, 4'hF, 16'd7, 16'd8, 1'b0, 1'b0);
    idle(2);

    // MUL with the next instruction held so it is taken in the DONE cycle
    applyStimulus(1'b1, 2'b10, 4'b1000, 16'd300, 16'd300, 1'b0, 1'b0);
    for (int i = 0; i < W + 1; i++) applyStimulus(1'b1, 2'b00, 4'h0, 16'd3, 16'd4, 1'b0, 1'b0);
    idle(2);

    // Division cases
    applyStimulus(1'b1, 2'b10, 4'b1001, 16'd100, 16'd7, 1'b0, 1'b0);
    idle(W + 2);
    applyStimulus(1'b1, 2'b10, 4'b1011, 16'd100, 16'd7, 1'b0, 1'b0);
    idle(W + 2);
    applyStimulus(1'b1, 2'b10, 4'b1001, 16'd100, 16'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b10, 4'b1011, 16'd100, 16'd0, 1'b0, 1'b0);
    idle(2);

    // Flush mid-MUL, then flush colliding with an accept in IDLE
    applyStimulus(1'b1, 2'b10, 4'b1000, 16'd300, 16'd300, 1'b0, 1'b0);
    idle(4);
    applyStimulus(1'b0, 2'b00, 4'h0, '0, '0, 1'b1, 1'b0);
    idle(W + 2);
    applyStimulus(1'b1, 2'b00, 4'h0, 16'd1, 16'd2, 1'b1, 1'b0);
    idle(2);

    // Reset mid-MUL
    applyStimulus(1'b1, 2'b10, 4'b1000, 16'd300, 16'd300, 1'b0, 1'b0);
    idle(4);
    applyStimulus(1'b0, 2'b00, 4'h0, '0, '0, 1'b0, 1'b1);
    idle(W + 2);

    // Back-to-back single-cycle ops
    applyStimulus(1'b1, 2'b10, 4'b0000, 16'd10, 16'd20, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b10, 4'b0100, 16'hF0F0, 16'h3C3C, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b10, 4'b0101, 16'hF0F0, 16'h0F0F, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b10, 4'b1010, 16'hFFFF, 16'd1, 1'b0, 1'b0);
    idle(2);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 9);
      aop = (r < 6) ? 2'b10 : 2'(r);
      f = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : legal_f[$urandom_range(0, 8)];
      x = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 20)) : W'($urandom);
      y = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 20)) : W'($urandom);
      applyStimulus(1'($urandom_range(0, 9) < 7), aop, f, x, y,
                    1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 199) == 0));
    end
    idle(W + 4);
    checkOutput("drain", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
